filtro_vizinhos: RTL
====================

FILTRO_VIZINHOS -- requirements
Module: filtro_vizinhos

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, node address width.
REQ-002 SHALL have parameter NUM_NEIGHBORS, default 8, neighbour slots per node; equals settled-flag read-port count.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, edge weight width.
REQ-004 SHALL define CNT_WIDTH = ceil(log2(NUM_NEIGHBORS+1)), default 4.
REQ-005 SHALL have port clk, input, 1, clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port soft_reset_n, input, 1, synchronous active-low flush.
REQ-008 SHALL have port in_valid, input, 1, neighbour list offered.
REQ-009 SHALL have port in_ready, output, 1, block can accept a list.
REQ-010 SHALL have port in_addr, input, ADDR_WIDTH*NUM_NEIGHBORS, packed neighbour addresses, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH].
REQ-011 SHALL have port in_weight, input, WEIGHT_WIDTH*NUM_NEIGHBORS, packed edge weights, same packing.
REQ-012 SHALL have port in_mask, input, NUM_NEIGHBORS, slot i holds a real edge when bit i = 1.
REQ-013 SHALL have port est_read_addr_out, output, ADDR_WIDTH*NUM_NEIGHBORS, addresses to settled-node memory read ports.
REQ-014 SHALL have port est_read_data_in, input, NUM_NEIGHBORS, settled flags returned combinationally for est_read_addr_out.
REQ-015 SHALL have port out_valid, output, 1, unsettled neighbour offered.
REQ-016 SHALL have port out_ready, input, 1, downstream (relaxation) accepts.
REQ-017 SHALL have port out_addr, output, ADDR_WIDTH, neighbour address.
REQ-018 SHALL have port out_weight, output, WEIGHT_WIDTH, matching edge weight.
REQ-019 SHALL have port out_last, output, 1, current offer is final one of the list.
REQ-020 SHALL have port done_out, output, 1, one-cycle pulse when list fully processed.
REQ-021 SHALL have port count_out, output, CNT_WIDTH, neighbours emitted for the list; valid while done_out = 1.

Function
REQ-022 SHALL implement FSM IDLE, LOOKUP, EMIT; in_ready = 1 only in IDLE.
REQ-023 SHALL, in IDLE on in_valid & in_ready, register in_addr, in_weight, in_mask and go to LOOKUP.
REQ-024 SHALL drive est_read_addr_out from the registered addresses at all times (reset value 0).
REQ-025 SHALL, in LOOKUP (exactly one cycle), load pending = mask_reg & ~est_read_data_in and clear the emit counter.
REQ-026 SHALL, from LOOKUP with pending = 0, return to IDLE and pulse done_out with count_out = 0.
REQ-027 SHALL, from LOOKUP with pending != 0, go to EMIT.
REQ-028 SHALL, in EMIT, assert out_valid and present the lowest-index pending slot on out_addr/out_weight.
REQ-029 SHALL assert out_last when exactly one pending bit remains.
REQ-030 SHALL, on out_valid & out_ready, clear that pending bit and increment the counter; held data is stable while out_ready = 0.
REQ-031 SHALL, on the transfer with out_last = 1, go to IDLE and pulse done_out the next cycle with the final count.
REQ-032 SHALL treat the LOOKUP snapshot as authoritative; flag changes during EMIT are ignored.
REQ-033 SHALL have no combinational path from in_* or out_ready to in_ready, out_valid or out_*.
REQ-034 SHALL accept a new list in the cycle after done_out is asserted, not earlier; throughput is one neighbour per cycle.

Reset
REQ-035 SHALL, on rst_n low, asynchronously enter IDLE; in_ready = 1 after release; out_valid, out_last, done_out = 0; out_addr, out_weight, count_out, stored registers, pending = 0.
REQ-036 SHALL, on soft_reset_n low at a clock edge, apply the REQ-035 values synchronously, in any state including mid-EMIT; in-flight list is dropped with no done_out; soft reset has priority over handshakes.

Verification
REQ-037 SHALL pass: mask 0xFF, addrs 1..8, weights 10..80, settled flags 0x00, out_ready = 1 -> 8 consecutive offers addr 1..8, out_last on addr 8, done_out with count_out = 8.
REQ-038 SHALL pass: mask 0x0F, settled flags 0x05 -> offers slot 1 then slot 3, out_last on slot 3, count_out = 2.
REQ-039 SHALL pass: mask 0x03, settled flags 0x03 -> no out_valid, done_out two cycles after accept, count_out = 0.
REQ-040 SHALL pass: out_ready held low 5 cycles during EMIT -> out_addr/out_weight stable, no bit cleared, in_ready = 0.
REQ-041 SHALL pass: soft_reset_n low after 2 of 6 emissions -> next cycle IDLE, out_valid = 0, no done_out; following list processed normally.
REQ-042 SHALL pass: settled flag of a pending slot set during EMIT -> that slot still emitted.

Source files
------------

// File: rtl/filtro_vizinhos.sv
// Neighbour filter: snapshots settled flags for a neighbour list and
// streams the unsettled, present neighbours out one per cycle.
module filtro_vizinhos #(
    parameter  int ADDR_WIDTH    = 8,
    parameter  int NUM_NEIGHBORS = 8,
    parameter  int WEIGHT_WIDTH  = 8,
    localparam int CNT_WIDTH     = $clog2(NUM_NEIGHBORS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  soft_reset_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ADDR_WIDTH*NUM_NEIGHBORS-1:0]   in_addr,
    input  logic [WEIGHT_WIDTH*NUM_NEIGHBORS-1:0] in_weight,
    input  logic [NUM_NEIGHBORS-1:0]              in_mask,
    output logic [ADDR_WIDTH*NUM_NEIGHBORS-1:0]   est_read_addr_out,
    input  logic [NUM_NEIGHBORS-1:0]              est_read_data_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ADDR_WIDTH-1:0]                 out_addr,
    output logic [WEIGHT_WIDTH-1:0]               out_weight,
    output logic                                  out_last,
    output logic                                  done_out,
    output logic [CNT_WIDTH-1:0]                  count_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        EMIT
    } state_t;

    localparam logic [NUM_NEIGHBORS-1:0] ONE = NUM_NEIGHBORS'(1);

    state_t                              state;
    logic [ADDR_WIDTH*NUM_NEIGHBORS-1:0]   addr_q;
    logic [WEIGHT_WIDTH*NUM_NEIGHBORS-1:0] weight_q;
    logic [NUM_NEIGHBORS-1:0]              mask_q;
    logic [NUM_NEIGHBORS-1:0]              pending;
    logic [CNT_WIDTH-1:0]                  cnt;
    logic [CNT_WIDTH-1:0]                  count_q;
    logic                                  done_q;

    logic [ADDR_WIDTH-1:0]    pick_addr;
    logic [WEIGHT_WIDTH-1:0]  pick_weight;
    logic [NUM_NEIGHBORS-1:0] pick_onehot;
    logic [NUM_NEIGHBORS-1:0] lookup_pending;
    logic                     last_one;

    // Descending scan so the lowest-index pending slot wins.
    always_comb begin
        pick_addr   = '0;
        pick_weight = '0;
        pick_onehot = '0;
        for (int i = NUM_NEIGHBORS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_addr      = addr_q[ADDR_WIDTH*i +: ADDR_WIDTH];
                pick_weight    = weight_q[WEIGHT_WIDTH*i +: WEIGHT_WIDTH];
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
            end
        end
    end

    assign lookup_pending = mask_q & ~est_read_data_in;
    assign last_one = (pending != '0) && ((pending & (pending - ONE)) == '0);

    assign in_ready          = (state == IDLE) && !done_q;
    assign out_valid         = (state == EMIT);
    assign out_last          = (state == EMIT) && last_one;
    assign out_addr          = pick_addr;
    assign out_weight        = pick_weight;
    assign done_out          = done_q;
    assign count_out         = count_q;
    assign est_read_addr_out = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            weight_q <= '0;
            mask_q   <= '0;
            pending  <= '0;
            cnt      <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else if (!soft_reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            weight_q <= '0;
            mask_q   <= '0;
            pending  <= '0;
            cnt      <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        addr_q   <= in_addr;
                        weight_q <= in_weight;
                        mask_q   <= in_mask;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    pending <= lookup_pending;
                    cnt     <= '0;
                    if (lookup_pending == '0) begin
                        state   <= IDLE;
                        done_q  <= 1'b1;
                        count_q <= '0;
                    end else begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending <= pending & ~pick_onehot;
                        cnt     <= cnt + CNT_WIDTH'(1);
                        if (last_one) begin
                            state   <= IDLE;
                            done_q  <= 1'b1;
                            count_q <= cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
